// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 scancode receiver.
package ps2_pkg;

    // Prefix bytes sent by the keyboard ahead of a scancode
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_ENTER = 8'h5A;

    // Frame FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_e;

    // PS/2 uses odd parity over the eight data bits plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// PS/2 line inputs and decoded key-event outputs of the scancode receiver.
interface ps2_scancode_rx_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic       key_make;
    logic       key_break;
    logic       key_extended;
    logic       frame_error;

    // Receiver side: samples the lines, drives the key events
    modport master (
        input  ps2_clk,
        input  ps2_dat,
        output ps2_key_data,
        output ps2_key_pressed,
        output key_make,
        output key_break,
        output key_extended,
        output frame_error
    );

    // Device/consumer side: drives the lines, observes the key events
    modport slave (
        output ps2_clk,
        output ps2_dat,
        input  ps2_key_data,
        input  ps2_key_pressed,
        input  key_make,
        input  key_break,
        input  key_extended,
        input  frame_error
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser plus saturating deglitch filter for one raw PS/2 line.
// The filtered level only changes after FILTER_LEN consecutive opposite samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             fall_q,  fall_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Count consecutive disagreeing samples; flip the level once the run is long enough
    always_comb begin
        sync1_d = line_i;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = level_q & ~level_d;
    end

    // State registers; the bus idles high so everything resets to 1
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// Host-side PS/2 keyboard receiver: deserialises 11-bit frames, checks
// start/parity/stop, and decodes E0/F0 prefixes into make/break events.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               userquit,
    ps2_scancode_rx_if.master  bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_fall;
    logic dat_level;
    logic clk_level_unused;
    logic dat_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (userquit),
        .line_i  (bus.ps2_clk),
        .level_o (clk_level_unused),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk     (clk),
        .rst     (userquit),
        .line_i  (bus.ps2_dat),
        .level_o (dat_level),
        .fall_o  (dat_fall_unused)
    );

    state_e           state_q,    state_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             parity_q,   parity_d;
    logic [TMO_W-1:0] tmo_q,      tmo_d;
    logic             ext_q,      ext_d;
    logic             brk_q,      brk_d;
    logic [7:0]       key_data_q, key_data_d;
    logic             pressed_q,  pressed_d;
    logic             make_q,     make_d;
    logic             break_q,    break_d;
    logic             extended_q, extended_d;
    logic             ferr_q,     ferr_d;

    // Frame FSM, timeout watchdog and prefix decode; strobes default low each cycle
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        key_data_d = key_data_q;
        pressed_d  = 1'b0;
        make_d     = 1'b0;
        break_d    = 1'b0;
        extended_d = 1'b0;
        ferr_d     = 1'b0;

        if (state_q == S_IDLE || clk_fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (clk_fall) begin
                    if (!dat_level) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                        shift_d   = 8'h00;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (clk_fall) begin
                    shift_d[bit_cnt_q] = dat_level;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (clk_fall) begin
                    parity_d = dat_level;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (clk_fall) begin
                    state_d = S_IDLE;
                    if (dat_level && odd_parity_ok(shift_q, parity_q)) begin
                        key_data_d = shift_q;
                        pressed_d  = 1'b1;
                        if (shift_q == PS2_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            make_d     = ~brk_q;
                            break_d    = brk_q;
                            extended_d = ext_q;
                            ext_d      = 1'b0;
                            brk_d      = 1'b0;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled partial frame is abandoned; a falling edge in the same cycle takes priority
        if (!clk_fall && state_q != S_IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_IDLE;
            ferr_d    = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
            shift_d   = 8'h00;
            bit_cnt_d = 3'd0;
            tmo_d     = '0;
        end
    end

    // State and output registers; userquit drops any partial frame
    always_ff @(posedge clk) begin
        if (userquit) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_data_q <= 8'h00;
            pressed_q  <= 1'b0;
            make_q     <= 1'b0;
            break_q    <= 1'b0;
            extended_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            key_data_q <= key_data_d;
            pressed_q  <= pressed_d;
            make_q     <= make_d;
            break_q    <= break_d;
            extended_q <= extended_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.ps2_key_data    = key_data_q;
    assign bus.ps2_key_pressed = pressed_q;
    assign bus.key_make        = make_q;
    assign bus.key_break       = break_q;
    assign bus.key_extended    = extended_q;
    assign bus.frame_error     = ferr_q;

endmodule
